// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and helpers.
// Used by the sequential divider and its trial-subtract adder.
package arith_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/cla.sv
// Carry-lookahead adder: sum = a + b + cin, with carry out.
// Generate/propagate terms feed a lookahead carry chain.
module cla #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign sum  = w_p ^ w_c[WIDTH-1:0];
    assign cout = w_c[WIDTH];

endmodule

// File: rtl/vedic_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Operands and results move over valid/ready handshakes.
module vedic_seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_t;
    logic             w_cout;
    logic             w_borrow;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH:0]   w_r_nxt;
    logic             w_accept;
    logic             w_last;

    // Trial subtract: shifted remainder + ~{0,D} + 1.
    assign w_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

    cla #(
        .WIDTH(WIDTH + 1)
    ) u_cla (
        .a   (w_shift),
        .b   (~{1'b0, r_d}),
        .cin (1'b1),
        .sum (w_t),
        .cout(w_cout)
    );

    assign w_borrow = ~w_cout;
    assign w_q_nxt  = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_r_nxt  = w_borrow ? w_shift : w_t;

    assign w_accept = in_valid && (r_state == DIV_IDLE);
    assign w_last   = (r_state == DIV_CALC) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DIV_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (divisor == '0) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (divisor == '0) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_q   <= dividend;
                r_d   <= divisor;
                r_r   <= '0;
                r_cnt <= CNT_W'(WIDTH - 1);
                r_dbz <= 1'b0;
            end
        end else if (r_state == DIV_CALC) begin
            r_q   <= w_q_nxt;
            r_r   <= w_r_nxt;
            r_cnt <= r_cnt - 1'b1;
            // Results only move on the final iteration so DONE holds them.
            if (w_last) begin
                r_quot <= w_q_nxt;
                r_rem  <= w_r_nxt[WIDTH-1:0];
            end
        end
    end

    assign in_ready    = (r_state == DIV_IDLE);
    assign out_valid   = (r_state == DIV_DONE);
    assign busy        = (r_state == DIV_CALC);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Self-checking bench for vedic_seq_divider (WIDTH=8).
// Directed cases plus randomized pairs against an arithmetic model.
module tb_vedic_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vedic_seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (b == 0) ? 8'hFF : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", busy, (b != 0));
        wait_out(lat);
        chk("latency", lat, (b == 0) ? 1 : W + 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, (b == 0));
        if (b != 0) begin
            chk("q*d+r", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("r<d", (remainder < b), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick();
        int s;
        s = $urandom_range(0, 15);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        int lat;
        rst = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(100, 7);
        do_op(255, 1);
        do_op(255, 255);
        do_op(3, 200);
        do_op(42, 0);
        do_op(0, 13);
        do_op(255, 0);

        // Back-pressure: results hold, new in_valid in DONE is ignored.
        @(negedge clk);
        dividend = 200;
        divisor  = 9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_latency", lat, W + 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = 17;
            divisor  = 4;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_quotient", quotient, 22);
            chk("bp_remainder", remainder, 2);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_not_taken", busy, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        wait_out(lat);
        chk("bp2_latency", lat, W + 1);
        chk("bp2_quotient", quotient, 4);
        chk("bp2_remainder", remainder, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        dividend = 99;
        divisor  = 0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        dividend = 77;
        divisor  = 3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(50, 5);

        for (int i = 0; i < 3000; i++) begin
            do_op(pick(), pick());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
